// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Constants and frame state encoding shared by the UART
//               receiver and transmitter on the 3.125 MHz domain.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // 3.125 MHz / 27 is roughly 115200 baud.
    localparam int CLKS_PER_BIT = 27;
    // Mid-bit sampling position within each bit period.
    localparam int SAMPLE_POINT = 13;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Frame state encoding.
    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_START     = 4'd1;
    localparam logic [3:0] ST_DATA      = 4'd2;
    localparam logic [3:0] ST_PARITY    = 4'd3;
    localparam logic [3:0] ST_STOP      = 4'd4;
    localparam logic [3:0] ST_WAIT_HIGH = 4'd5;

    // Parity bit a correct frame carries for the given data byte.
    function automatic logic expected_parity(input logic [7:0] data,
                                             input logic       ptype);
        return (ptype == PARITY_ODD) ? ~^data : ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchronizer for the asynchronous serial line plus
//               a delay flop used to detect a falling edge.
// Ports       : clk_3125 - system clock
//               rst_n    - asynchronous active-low reset
//               rx       - raw serial line (asynchronous)
//               rx_s     - synchronized line
//               rx_fall  - high for one cycle when rx_s goes 1 -> 0
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  logic clk_3125,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s,
    output logic rx_fall
);

    logic r_meta;
    logic r_sync;
    logic r_dly;

    // All flops reset to the idle (high) line level so that reset release
    // never looks like a start edge.
    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_dly  <= 1'b1;
        end else begin
            r_meta <= rx;
            r_sync <= r_meta;
            r_dly  <= r_sync;
        end
    end

    assign rx_s    = r_sync;
    // Decoded purely from flop outputs, so it is glitch-free.
    assign rx_fall = r_dly & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8-bit UART receiver: 1 start, 8 data (LSB first), 1 parity,
//               1 stop bit. Presents each byte with a one-cycle completion
//               pulse plus parity and framing status.
// Ports       : clk_3125    - 3.125 MHz system clock
//               rst_n       - asynchronous active-low reset
//               rx          - serial line, idles high
//               parity_type - 0 even, 1 odd
//               rx_msg      - last received byte
//               rx_parity   - last received parity bit
//               rx_complete - one-cycle pulse when outputs update
//               parity_err  - parity check of last frame failed
//               frame_err   - stop bit of last frame sampled low
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
    parameter int SAMPLE_POINT = uart_pkg::SAMPLE_POINT
) (
    input  logic       clk_3125,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       parity_type,
    output logic [7:0] rx_msg,
    output logic       rx_parity,
    output logic       rx_complete,
    output logic       parity_err,
    output logic       frame_err
);

    import uart_pkg::*;

    localparam logic [4:0] c_LAST   = 5'(CLKS_PER_BIT - 1);
    localparam logic [4:0] c_SAMPLE = 5'(SAMPLE_POINT);

    logic       w_rx_s;
    logic       w_rx_fall;
    logic       w_bit_end;
    logic       w_sample;

    logic [3:0] r_state;
    logic [4:0] r_cnt;
    logic [2:0] r_bit_idx;
    logic [7:0] r_shift;
    logic       r_ptype;
    logic       r_par_bit;

    uart_rx_sync u_sync (
        .clk_3125 (clk_3125),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_s     (w_rx_s),
        .rx_fall  (w_rx_fall)
    );

    assign w_bit_end = (r_cnt == c_LAST);
    assign w_sample  = (r_cnt == c_SAMPLE);

    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 5'd0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'd0;
            r_ptype     <= PARITY_EVEN;
            r_par_bit   <= 1'b0;
            rx_msg      <= 8'd0;
            rx_parity   <= 1'b0;
            rx_complete <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_complete <= 1'b0;

            // Free-running bit timer while inside a frame; state branches
            // below override it where a frame starts or ends.
            if (w_bit_end) begin
                r_cnt <= 5'd0;
            end else begin
                r_cnt <= r_cnt + 5'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    // The edge that detects the fall is count 0 of the start
                    // bit, so the next cycle already sees count 1.
                    if (w_rx_fall) begin
                        r_state <= ST_START;
                        r_cnt   <= 5'd1;
                    end else begin
                        r_cnt   <= 5'd0;
                    end
                end

                ST_START: begin
                    if (w_sample) begin
                        if (w_rx_s) begin
                            // Line went back high: glitch, not a start bit.
                            r_state <= ST_IDLE;
                            r_cnt   <= 5'd0;
                        end else begin
                            r_ptype <= parity_type;
                        end
                    end else if (w_bit_end) begin
                        r_state   <= ST_DATA;
                        r_bit_idx <= 3'd0;
                    end
                end

                ST_DATA: begin
                    if (w_sample) begin
                        r_shift <= {w_rx_s, r_shift[7:1]};
                    end
                    if (w_bit_end) begin
                        if (r_bit_idx == 3'd7) begin
                            r_state   <= ST_PARITY;
                            r_bit_idx <= 3'd0;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (w_sample) begin
                        r_par_bit <= w_rx_s;
                    end
                    if (w_bit_end) begin
                        r_state <= ST_STOP;
                    end
                end

                ST_STOP: begin
                    // Leave at mid-stop so that a zero-gap next start edge
                    // is already seen in IDLE.
                    if (w_sample) begin
                        rx_msg      <= r_shift;
                        rx_parity   <= r_par_bit;
                        parity_err  <= (r_par_bit != expected_parity(r_shift, r_ptype));
                        frame_err   <= ~w_rx_s;
                        rx_complete <= 1'b1;
                        r_cnt       <= 5'd0;
                        r_state     <= w_rx_s ? ST_IDLE : ST_WAIT_HIGH;
                    end
                end

                ST_WAIT_HIGH: begin
                    // A stuck-low line must not be decoded as new frames.
                    r_cnt <= 5'd0;
                    if (w_rx_s) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 5'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed self-checking bench for uart_rx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int c_BIT     = 27;
    localparam int c_LATENCY = 286;
    localparam int c_FRAME   = 11 * c_BIT;

    logic       clk_3125    = 1'b0;
    logic       rst_n       = 1'b0;
    logic       rx          = 1'b1;
    logic       parity_type = 1'b0;
    logic [7:0] rx_msg;
    logic       rx_parity;
    logic       rx_complete;
    logic       parity_err;
    logic       frame_err;

    uart_rx dut (
        .clk_3125    (clk_3125),
        .rst_n       (rst_n),
        .rx          (rx),
        .parity_type (parity_type),
        .rx_msg      (rx_msg),
        .rx_parity   (rx_parity),
        .rx_complete (rx_complete),
        .parity_err  (parity_err),
        .frame_err   (frame_err)
    );

    always #5 clk_3125 = ~clk_3125;

    int cyc = 0;
    always @(posedge clk_3125) cyc <= cyc + 1;

    // Pulse recorder, sampled on the falling edge.
    int         n_pulse  = 0;
    int         n_double = 0;
    logic       prev_c   = 1'b0;
    int         p_cyc  [32];
    logic [7:0] p_msg  [32];
    logic       p_par  [32];
    logic       p_perr [32];
    logic       p_ferr [32];

    always @(negedge clk_3125) begin
        if (rx_complete === 1'b1) begin
            if (n_pulse < 32) begin
                p_cyc[n_pulse]  <= cyc;
                p_msg[n_pulse]  <= rx_msg;
                p_par[n_pulse]  <= rx_parity;
                p_perr[n_pulse] <= parity_err;
                p_ferr[n_pulse] <= frame_err;
            end
            n_pulse <= n_pulse + 1;
            if (prev_c) n_double <= n_double + 1;
        end
        prev_c <= (rx_complete === 1'b1);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk();
        @(posedge clk_3125);
        #1;
    endtask

    // Drives one full frame; t0 is the cycle stamp at which the start bit
    // began on the pin.
    task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb,
                              output int t0);
        t0 = cyc;
        rx = 1'b0;
        repeat (c_BIT) wait_clk();
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (c_BIT) wait_clk();
        end
        rx = pb;
        repeat (c_BIT) wait_clk();
        rx = sb;
        repeat (c_BIT) wait_clk();
    endtask

    initial begin
        int t0, t1, t2, np;

        repeat (3) wait_clk();
        check("rst_msg",      32'(rx_msg),      32'h0);
        check("rst_parity",   32'(rx_parity),   32'h0);
        check("rst_complete", 32'(rx_complete), 32'h0);
        check("rst_perr",     32'(parity_err),  32'h0);
        check("rst_ferr",     32'(frame_err),   32'h0);
        rst_n = 1'b1;
        repeat (5) wait_clk();

        // 0x5A even parity
        np = n_pulse;
        parity_type = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b1, t0);
        check("5a_count", 32'(n_pulse - np), 32'd1);
        check("5a_time",  32'(p_cyc[np]),    32'(t0 + c_LATENCY));
        check("5a_msg",   32'(p_msg[np]),    32'h5A);
        check("5a_par",   32'(p_par[np]),    32'h0);
        check("5a_perr",  32'(p_perr[np]),   32'h0);
        check("5a_ferr",  32'(p_ferr[np]),   32'h0);

        // 0xA5 odd parity, wrong parity bit, then 0x01 even correct
        np = n_pulse;
        parity_type = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b1, t0);
        parity_type = 1'b0;
        send_frame(8'h01, 1'b1, 1'b1, t0);
        check("a5_count", 32'(n_pulse - np),  32'd2);
        check("a5_msg",   32'(p_msg[np]),     32'hA5);
        check("a5_perr",  32'(p_perr[np]),    32'h1);
        check("01_msg",   32'(p_msg[np+1]),   32'h01);
        check("01_par",   32'(p_par[np+1]),   32'h1);
        check("01_perr",  32'(p_perr[np+1]),  32'h0);

        // 0xFF with stop low, line held low, then released
        np = n_pulse;
        send_frame(8'hFF, 1'b0, 1'b0, t0);
        repeat (100) wait_clk();
        check("ff_count_low", 32'(n_pulse - np), 32'd1);
        check("ff_msg",       32'(p_msg[np]),    32'hFF);
        check("ff_ferr",      32'(p_ferr[np]),   32'h1);
        check("ff_perr",      32'(p_perr[np]),   32'h0);
        rx = 1'b1;
        repeat (40) wait_clk();
        check("ff_count_high", 32'(n_pulse - np), 32'd1);

        // 8-cycle glitch, then 0x3C
        np = n_pulse;
        rx = 1'b0;
        repeat (8) wait_clk();
        rx = 1'b1;
        repeat (60) wait_clk();
        check("glitch_count", 32'(n_pulse - np), 32'd0);
        send_frame(8'h3C, 1'b0, 1'b1, t0);
        check("3c_count", 32'(n_pulse - np), 32'd1);
        check("3c_msg",   32'(p_msg[np]),    32'h3C);
        check("3c_perr",  32'(p_perr[np]),   32'h0);
        check("3c_ferr",  32'(p_ferr[np]),   32'h0);

        // Back-to-back 0x00, 0xFF, 0x81 with zero gap
        repeat (20) wait_clk();
        np = n_pulse;
        send_frame(8'h00, 1'b0, 1'b1, t0);
        send_frame(8'hFF, 1'b0, 1'b1, t1);
        send_frame(8'h81, 1'b0, 1'b1, t2);
        check("b2b_count", 32'(n_pulse - np), 32'd3);
        check("b2b_msg0",  32'(p_msg[np]),    32'h00);
        check("b2b_msg1",  32'(p_msg[np+1]),  32'hFF);
        check("b2b_msg2",  32'(p_msg[np+2]),  32'h81);
        check("b2b_gap01", 32'(p_cyc[np+1] - p_cyc[np]),   32'(c_FRAME));
        check("b2b_gap12", 32'(p_cyc[np+2] - p_cyc[np+1]), 32'(c_FRAME));
        check("b2b_err",   32'({p_perr[np], p_ferr[np], p_perr[np+1], p_ferr[np+1],
                                p_perr[np+2], p_ferr[np+2]}), 32'h0);

        // Reset during data bit 4 of 0x77
        repeat (20) wait_clk();
        np = n_pulse;
        rx = 1'b0;
        repeat (c_BIT) wait_clk();
        for (int i = 0; i < 4; i++) begin
            rx = (i == 3) ? 1'b0 : 1'b1;   // 0x77 bits 0..3 = 1,1,1,0
            repeat (c_BIT) wait_clk();
        end
        rx = 1'b1;                          // bit 4 of 0x77
        repeat (10) wait_clk();
        rst_n = 1'b0;
        #1;
        check("arst_msg",  32'(rx_msg),   32'h0);
        check("arst_flag", 32'({rx_parity, rx_complete, parity_err, frame_err}), 32'h0);
        repeat (3) wait_clk();
        rst_n = 1'b1;
        rx = 1'b1;
        repeat (300) wait_clk();
        check("arst_count", 32'(n_pulse - np), 32'd0);
        send_frame(8'h12, 1'b0, 1'b1, t0);
        check("12_count", 32'(n_pulse - np), 32'd1);
        check("12_time",  32'(p_cyc[np]),    32'(t0 + c_LATENCY));
        check("12_msg",   32'(p_msg[np]),    32'h12);
        check("12_err",   32'({p_perr[np], p_ferr[np]}), 32'h0);

        check("pulse_width", 32'(n_double), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
